// File: rtl/branch_history_table_2bc_pkg.sv
// Shared types and helpers for the 2-bit-counter branch history table:
// the table entry layout, the weak counter encodings and the saturating update.
package branch_history_table_2bc_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    typedef enum logic {
        INIT,
        RUN
    } bht_state_e;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
    localparam logic [1:0] CTR_WEAK_NT    = 2'b01;

    // Counts toward 3 on taken and toward 0 on not-taken, holding at either end.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_history_table_2bc_sat_counter.sv
// Next-state of one table entry for a resolved branch; a cold entry starts at
// the weak counter matching the first observed outcome.
module bht_sat_counter
    import branch_history_table_2bc_pkg::*;
(
    input  bht_entry_t cur_entry,
    input  logic       taken,
    output bht_entry_t next_entry
);

    always_comb begin
        next_entry.valid = 1'b1;
        if (!cur_entry.valid) begin
            next_entry.ctr = taken ? CTR_WEAK_TAKEN : CTR_WEAK_NT;
        end else begin
            next_entry.ctr = sat_update(cur_entry.ctr, taken);
        end
    end

endmodule

// File: rtl/branch_history_table_2bc.sv
// Direct-mapped table of 2-bit saturating counters trained by resolved branches
// and read by fetch with one cycle of latency; cleared by a sweep after reset or flush.
module branch_history_table_2bc
    import branch_history_table_2bc_pkg::*;
#(
    parameter int unsigned VLEN       = 39,
    parameter int unsigned NR_ENTRIES = 1024,
    localparam int unsigned IDX_BITS  = $clog2(NR_ENTRIES)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            resolve_valid_i,
    input  logic [VLEN-1:0] resolve_pc_i,
    input  logic            resolve_is_branch_i,
    input  logic            resolve_taken_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            ready_o,
    output logic            predict_valid_o,
    output logic            predict_taken_o
);

    bht_state_e          state;
    logic [IDX_BITS-1:0] sweep;
    bht_entry_t          table_q [NR_ENTRIES];

    logic                s1_valid;
    logic [IDX_BITS-1:0] s1_idx;
    logic                s1_taken;

    logic                run;
    logic [IDX_BITS-1:0] resolve_idx;
    logic [IDX_BITS-1:0] lookup_idx;
    bht_entry_t          s2_cur;
    bht_entry_t          s2_next;
    logic                s2_we;
    bht_entry_t          lookup_entry;
    logic                unused_pc_bits;

    // Halfword-granular index so compressed branches get their own entries.
    assign resolve_idx    = resolve_pc_i[IDX_BITS:1];
    assign lookup_idx     = lookup_pc_i[IDX_BITS:1];
    assign unused_pc_bits = ^{resolve_pc_i[VLEN-1:IDX_BITS+1], resolve_pc_i[0],
                              lookup_pc_i[VLEN-1:IDX_BITS+1], lookup_pc_i[0]};

    assign run     = (state == RUN);
    assign ready_o = run;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= INIT;
            sweep <= '0;
        end else if (flush_i) begin
            state <= INIT;
            sweep <= '0;
        end else if (state == INIT) begin
            if (sweep == IDX_BITS'(NR_ENTRIES - 1)) begin
                state <= RUN;
            end
            sweep <= sweep + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_taken <= 1'b0;
        end else begin
            s1_valid <= resolve_valid_i & resolve_is_branch_i & ~debug_mode_i & run & ~flush_i;
            s1_idx   <= resolve_idx;
            s1_taken <= resolve_taken_i;
        end
    end

    assign s2_cur = table_q[s1_idx];
    assign s2_we  = s1_valid & run & ~flush_i;

    bht_sat_counter u_sat_counter (
        .cur_entry  (s2_cur),
        .taken      (s1_taken),
        .next_entry (s2_next)
    );

    // No reset on the storage so it can map onto an SRAM macro; the sweep clears it.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            table_q[sweep] <= '0;
        end else if (s2_we) begin
            table_q[s1_idx] <= s2_next;
        end
    end

    assign lookup_entry = (s2_we && (s1_idx == lookup_idx)) ? s2_next : table_q[lookup_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            predict_valid_o <= 1'b0;
            predict_taken_o <= 1'b0;
        end else begin
            predict_valid_o <= lookup_valid_i & run & lookup_entry.valid;
            predict_taken_o <= lookup_valid_i & run & lookup_entry.valid & lookup_entry.ctr[1];
        end
    end

endmodule

// File: tb/tb_branch_history_table_2bc.sv
// Directed bench for branch_history_table_2bc: init sweep, training, saturation,
// write bypass, filtering and flush behaviour with hand-computed expectations.
module tb_branch_history_table_2bc;

    localparam int unsigned VLEN       = 39;
    localparam int unsigned NR_ENTRIES = 1024;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            debug_mode_i;
    logic            resolve_valid_i;
    logic [VLEN-1:0] resolve_pc_i;
    logic            resolve_is_branch_i;
    logic            resolve_taken_i;
    logic            lookup_valid_i;
    logic [VLEN-1:0] lookup_pc_i;
    logic            ready_o;
    logic            predict_valid_o;
    logic            predict_taken_o;

    int vectors    = 0;
    int miscompares = 0;
    int cnt;

    branch_history_table_2bc #(
        .VLEN       (VLEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .debug_mode_i        (debug_mode_i),
        .resolve_valid_i     (resolve_valid_i),
        .resolve_pc_i        (resolve_pc_i),
        .resolve_is_branch_i (resolve_is_branch_i),
        .resolve_taken_i     (resolve_taken_i),
        .lookup_valid_i      (lookup_valid_i),
        .lookup_pc_i         (lookup_pc_i),
        .ready_o             (ready_o),
        .predict_valid_o     (predict_valid_o),
        .predict_taken_o     (predict_taken_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the clock edge.
    task automatic applyStimulus(input logic rv, input logic [VLEN-1:0] rpc, input logic isb,
                                 input logic tk, input logic dbg, input logic lv,
                                 input logic [VLEN-1:0] lpc, input logic fl);
        resolve_valid_i     = rv;
        resolve_pc_i        = rpc;
        resolve_is_branch_i = isb;
        resolve_taken_i     = tk;
        debug_mode_i        = dbg;
        lookup_valid_i      = lv;
        lookup_pc_i         = lpc;
        flush_i             = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolveBranch(input logic [VLEN-1:0] pc, input logic tk);
        applyStimulus(1'b1, pc, 1'b1, tk, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic lookup(input logic [VLEN-1:0] pc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, pc, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        debug_mode_i = 1'b0;
        resolve_valid_i = 1'b0;
        resolve_pc_i = '0;
        resolve_is_branch_i = 1'b0;
        resolve_taken_i = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_pc_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", {31'b0, ready_o}, 32'd0);
        checkOutput("reset_pvalid", {31'b0, predict_valid_o}, 32'd0);
        checkOutput("reset_ptaken", {31'b0, predict_taken_o}, 32'd0);

        // Init sweep: ready must stay low for exactly NR_ENTRIES edges.
        rst_ni = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_pc_i = 39'h80;
        cnt = 0;
        while (!ready_o && cnt < 2000) begin
            @(posedge clk_i);
            #1;
            cnt++;
            if (cnt == 5) checkOutput("init_lookup_valid", {31'b0, predict_valid_o}, 32'd0);
        end
        checkOutput("init_sweep_len", cnt, NR_ENTRIES);
        lookup(39'h80);
        checkOutput("swept_entry_valid", {31'b0, predict_valid_o}, 32'd0);

        // Cold train then warm down to 0, then one taken must give ctr=1.
        resolveBranch(39'h80, 1'b1);
        idle();
        lookup(39'h80);
        checkOutput("cold_taken_valid", {31'b0, predict_valid_o}, 32'd1);
        checkOutput("cold_taken_dir", {31'b0, predict_taken_o}, 32'd1);
        resolveBranch(39'h80, 1'b0);
        idle();
        lookup(39'h80);
        checkOutput("warm_nt1_dir", {31'b0, predict_taken_o}, 32'd0);
        resolveBranch(39'h80, 1'b0);
        idle();
        lookup(39'h80);
        checkOutput("warm_nt2_valid", {31'b0, predict_valid_o}, 32'd1);
        checkOutput("warm_nt2_dir", {31'b0, predict_taken_o}, 32'd0);
        resolveBranch(39'h80, 1'b1);
        idle();
        lookup(39'h80);
        checkOutput("floor_no_wrap_dir", {31'b0, predict_taken_o}, 32'd0);

        // Saturation at 3: five taken, then 3->2 (taken) and 2->1 (not taken).
        repeat (5) resolveBranch(39'h100, 1'b1);
        idle();
        lookup(39'h100);
        checkOutput("sat_taken_dir", {31'b0, predict_taken_o}, 32'd1);
        resolveBranch(39'h100, 1'b0);
        idle();
        lookup(39'h100);
        checkOutput("sat_nt1_valid", {31'b0, predict_valid_o}, 32'd1);
        checkOutput("sat_nt1_dir", {31'b0, predict_taken_o}, 32'd1);
        resolveBranch(39'h100, 1'b0);
        idle();
        lookup(39'h100);
        checkOutput("sat_nt2_dir", {31'b0, predict_taken_o}, 32'd0);

        // Back-to-back taken at a cold entry with lookups overlapping the writes.
        resolveBranch(39'h40, 1'b1);
        applyStimulus(1'b1, 39'h40, 1'b1, 1'b1, 1'b0, 1'b1, 39'h40, 1'b0);
        checkOutput("bypass_first_valid", {31'b0, predict_valid_o}, 32'd1);
        checkOutput("bypass_first_dir", {31'b0, predict_taken_o}, 32'd1);
        lookup(39'h40);
        checkOutput("bypass_second_valid", {31'b0, predict_valid_o}, 32'd1);
        checkOutput("bypass_second_dir", {31'b0, predict_taken_o}, 32'd1);
        resolveBranch(39'h40, 1'b0);
        idle();
        lookup(39'h40);
        checkOutput("b2b_no_lost_update", {31'b0, predict_taken_o}, 32'd1);

        // Filtered resolutions must not allocate an entry.
        applyStimulus(1'b1, 39'h200, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
        lookup(39'h200);
        checkOutput("filter_not_branch", {31'b0, predict_valid_o}, 32'd0);
        applyStimulus(1'b1, 39'h200, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle();
        lookup(39'h200);
        checkOutput("filter_debug_mode", {31'b0, predict_valid_o}, 32'd0);

        // Flush coinciding with a resolve, then a second flush at sweep=100.
        applyStimulus(1'b1, 39'h300, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("flush_ready_drop", {31'b0, ready_o}, 32'd0);
        repeat (100) idle();
        checkOutput("mid_sweep_ready", {31'b0, ready_o}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        flush_i = 1'b0;
        cnt = 0;
        while (!ready_o && cnt < 2000) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
        checkOutput("flush_sweep_len", cnt, NR_ENTRIES);
        lookup(39'h300);
        checkOutput("flush_drops_update", {31'b0, predict_valid_o}, 32'd0);
        lookup(39'h100);
        checkOutput("flush_clears_table", {31'b0, predict_valid_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
